qpsk_ctrl: RTL and testbench

Sequencing controller for the QPSK FPGA top level. It synchronizes the board switches and generates the symbol-rate clock enable that paces the PRBS generators and TX filter. It gates TX and RX enables only at symbol boundaries, selects the RX downsampling phase, and drains the TX filter with zero symbols on shutdown so no partial pulse is left in the taps.

---
 rtl/qpsk_ctrl.sv | 155 +++++++++++++++
 tb/tb_qpsk_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/qpsk_ctrl.sv
// qpsk_ctrl: QPSK top-level sequencing controller.
// Synchronizes board switches, generates the symbol-rate clock enable,
// gates TX/RX enables at symbol boundaries, selects the RX sampling phase
// and drains the TX filter with zero symbols on shutdown.
// Optional feature macro: QPSK_CTRL_LED_EN (status LEDs + heartbeat on o_led).
module qpsk_ctrl #(
   parameter int unsigned NOS       = 4,
   parameter int unsigned FLUSH_LEN = 6
) (
   input  logic       CLK100MHZ,
   input  logic       rst,
   input  logic [3:0] i_switch,
   output logic       o_sym_ce,
   output logic       o_tx_en,
   output logic       o_rx_en,
   output logic       o_flush,
   output logic [1:0] o_phase
`ifdef QPSK_CTRL_LED_EN
  ,output logic [3:0] o_led
`endif
);

   localparam int unsigned CW = (NOS > 2) ? $clog2(NOS) : 1;
   localparam int unsigned FW = 8;
   localparam int unsigned HW = 20;
   localparam logic [CW-1:0] CNT_LAST = CW'(NOS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_TX   = 2'd1,
      RUN_TXRX = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [FW-1:0] r_fcnt;
   logic          r_sym_ce;
   logic          r_tx_en;
   logic          r_rx_en;
   logic          r_flush;
   logic [1:0]    r_phase;

   logic [3:0]    w_sw_s;
   logic          w_bnd;
   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [FW-1:0] w_fcnt_nxt;
   logic [1:0]    w_phase_nxt;

   assign w_sw_s = r_sync2;
   assign w_bnd  = (r_cnt == CNT_LAST);

   // Two-flop synchronizer on the raw switches
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_switch;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state, symbol counter, flush counter and phase selection
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_fcnt_nxt  = '0;
      w_phase_nxt = r_phase;

      case (r_state)
         IDLE: begin
            if (w_sw_s[0]) w_state_nxt = RUN_TX;
         end
         RUN_TX: begin
            if (w_bnd) begin
               if (!w_sw_s[0])     w_state_nxt = FLUSH;
               else if (w_sw_s[1]) w_state_nxt = RUN_TXRX;
            end
         end
         RUN_TXRX: begin
            if (w_bnd) begin
               if (!w_sw_s[0])      w_state_nxt = FLUSH;
               else if (!w_sw_s[1]) w_state_nxt = RUN_TX;
            end
         end
         FLUSH: begin
            // Switches are ignored until all zero symbols have been issued
            if (w_bnd && (r_fcnt == FW'(FLUSH_LEN)))
               w_state_nxt = w_sw_s[0] ? RUN_TX : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      if (r_state != IDLE)
         w_cnt_nxt = w_bnd ? '0 : r_cnt + CW'(1);

      if ((r_state == FLUSH) && (w_state_nxt == FLUSH))
         w_fcnt_nxt = r_sym_ce ? r_fcnt + FW'(1) : r_fcnt;

      if ((r_state != IDLE) && w_bnd)
         w_phase_nxt = 2'(32'(w_sw_s[3:2]) % NOS);
   end

   // State register with outputs registered from the next-state decode
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_fcnt   <= '0;
         r_sym_ce <= 1'b0;
         r_tx_en  <= 1'b0;
         r_rx_en  <= 1'b0;
         r_flush  <= 1'b0;
         r_phase  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_fcnt   <= w_fcnt_nxt;
         r_sym_ce <= (w_state_nxt != IDLE) && (w_cnt_nxt == '0);
         r_tx_en  <= (w_state_nxt != IDLE);
         r_rx_en  <= (w_state_nxt == RUN_TXRX);
         r_flush  <= (w_state_nxt == FLUSH);
         r_phase  <= w_phase_nxt;
      end
   end

   assign o_sym_ce = r_sym_ce;
   assign o_tx_en  = r_tx_en;
   assign o_rx_en  = r_rx_en;
   assign o_flush  = r_flush;
   assign o_phase  = r_phase;

`ifdef QPSK_CTRL_LED_EN
   logic [HW-1:0] r_hb_cnt;
   logic          r_hb;

   // Heartbeat: toggle once per 2^20 symbol enables
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         r_hb_cnt <= '0;
         r_hb     <= 1'b0;
      end else if (r_sym_ce) begin
         r_hb_cnt <= r_hb_cnt + HW'(1);
         if (r_hb_cnt == '1) r_hb <= ~r_hb;
      end
   end

   assign o_led = {r_hb, r_flush, r_rx_en, r_tx_en};
`endif

endmodule

// File: tb/tb_qpsk_ctrl.sv
// Testbench for qpsk_ctrl: cycle model feeds an expected-output queue,
// DUT outputs are popped and compared on the falling edge.
module tb_qpsk_ctrl;

   localparam int NOS       = 4;
   localparam int FLUSH_LEN = 6;

   logic       CLK100MHZ;
   logic       rst;
   logic [3:0] i_switch;
   logic       o_sym_ce;
   logic       o_tx_en;
   logic       o_rx_en;
   logic       o_flush;
   logic [1:0] o_phase;
`ifdef QPSK_CTRL_LED_EN
   logic [3:0] o_led;
`endif

   qpsk_ctrl #(.NOS(NOS), .FLUSH_LEN(FLUSH_LEN)) u_dut (
      .CLK100MHZ (CLK100MHZ),
      .rst       (rst),
      .i_switch  (i_switch),
      .o_sym_ce  (o_sym_ce),
      .o_tx_en   (o_tx_en),
      .o_rx_en   (o_rx_en),
      .o_flush   (o_flush),
      .o_phase   (o_phase)
`ifdef QPSK_CTRL_LED_EN
     ,.o_led     (o_led)
`endif
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   int n_checks = 0;
   int n_errors = 0;

   logic [5:0] exp_q[$];

   // Model state: symbol-level view (on/off, rx, flushing with symbols left)
   logic [3:0] m_s1, m_s2;
   bit         m_on, m_rx, m_fl;
   int         m_t, m_left;
   logic [1:0] m_phase;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0;
      m_on = 0; m_rx = 0; m_fl = 0;
      m_t = 0; m_left = 0; m_phase = '0;
   endtask

   task automatic model_step();
      logic [3:0] s;
      bit bnd;
      if (!rst) begin
         model_reset();
         return;
      end
      s = m_s2; m_s2 = m_s1; m_s1 = i_switch;
      if (!m_on) begin
         if (s[0]) begin m_on = 1; m_t = 0; m_rx = 0; m_fl = 0; end
      end else begin
         bnd = (m_t == NOS - 1);
         m_t = bnd ? 0 : m_t + 1;
         if (bnd) begin
            m_phase = 2'(int'(s[3:2]) % NOS);
            if (m_fl) begin
               m_left--;
               if (m_left == 0) begin
                  m_fl = 0; m_rx = 0; m_on = s[0]; m_t = 0;
               end
            end else if (!s[0]) begin
               m_fl = 1; m_left = FLUSH_LEN; m_rx = 0;
            end else begin
               m_rx = s[1];
            end
         end
      end
   endtask

   function automatic logic [5:0] model_out();
      return {(m_on && m_t == 0), m_on, (m_on && m_rx), m_fl, m_phase};
   endfunction

   // One clock: model predicts at the rising edge, DUT compared at the falling edge
   task automatic tick();
      logic [5:0] e;
      @(posedge CLK100MHZ);
      model_step();
      exp_q.push_back(model_out());
      @(negedge CLK100MHZ);
      e = exp_q.pop_front();
      check("outs", {26'd0, o_sym_ce, o_tx_en, o_rx_en, o_flush, o_phase}, {26'd0, e});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tx_latency(output int n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         if (o_tx_en) break;
      end
   endtask

   int lat, pulses, fcycles;
   bit seen;

   initial begin
      rst = 1'b0;
      i_switch = 4'b1000;
      model_reset();
      ticks(3);
      check("rst_outs", {27'd0, o_sym_ce, o_tx_en, o_rx_en, o_flush}, 32'd0);
      check("rst_phase", 32'(o_phase), 32'd0);
      rst = 1'b1;
      ticks(4);

      // Enable TX: 3-cycle latency, phase 2 after first boundary
      i_switch = 4'b1001;
      tx_latency(lat);
      check("tx_lat", 32'(lat), 32'd3);
      check("first_ce", 32'(o_sym_ce), 32'd1);
      ticks(4);
      check("phase", 32'(o_phase), 32'd2);
      ticks(1);

      // RX enable mid-symbol, plus a phase change
      i_switch = 4'b1111;
      ticks(13);

      // Drop TX in RUN_TXRX: flush of FLUSH_LEN pulses
      i_switch = 4'b1110;
      pulses = 0; fcycles = 0; seen = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (o_flush) begin
            seen = 1; fcycles++;
            if (o_sym_ce) pulses++;
         end else if (seen) break;
      end
      check("flush_pulses", 32'(pulses), 32'(FLUSH_LEN));
      check("flush_cycles", 32'(fcycles), 32'(FLUSH_LEN * NOS));
      ticks(8);
      check("idle_tx", 32'(o_tx_en), 32'd0);

      // Restart, then re-assert TX mid-flush
      i_switch = 4'b0001;
      ticks(12);
      i_switch = 4'b0000;
      ticks(9);
      i_switch = 4'b0001;
      ticks(30);
      check("resume_tx", 32'(o_tx_en), 32'd1);

      // Simultaneous TX drop and RX raise: flush wins
      i_switch = 4'b0010;
      ticks(35);

      // Reset mid-flush with TX held on
      i_switch = 4'b0101;
      ticks(10);
      i_switch = 4'b0100;
      ticks(8);
      i_switch = 4'b0101;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_outs", {27'd0, o_sym_ce, o_tx_en, o_rx_en, o_flush}, 32'd0);
      check("mid_rst_phase", 32'(o_phase), 32'd0);
      model_reset();
      ticks(2);
      rst = 1'b1;
      tx_latency(lat);
      check("rst_tx_lat", 32'(lat), 32'd3);
      ticks(20);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
